// File: rtl/k_cmult_arb.sv
// Round-robin arbiter that shares one combinational complex multiplier
// among NREQ requesters and registers each product with its owner id.
module k_cmult_arb #(
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          mul_in0,
    output logic [15:0]          mul_in1,
    input  logic [15:0]          mul_out,
    output logic                 res_valid,
    output logic [15:0]          res_data,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_ready,
    output logic [15:0]          op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [15:0]     op_count_q, op_count_d;

    logic            slot_free;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW:0]    sum;

    assign slot_free = (state_q == EMPTY) || res_ready;

    // Scan from ptr upward with wrap; first valid index wins.
    // Reset gates the grant so req_ready stays low while rst is high.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        if (slot_free && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                sum = {1'b0, ptr_q} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NREQ)) begin
                    sum = sum - (IDW+1)'(NREQ);
                end
                if (!gnt_any && req_valid[sum[IDW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = sum[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_in0   = '0;
        mul_in1   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_any && (gnt_idx == IDW'(k))) begin
                req_ready[k] = 1'b1;
                mul_in0      = req_a[16*k +: 16];
                mul_in1      = req_b[16*k +: 16];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        ptr_d      = ptr_q;
        op_count_d = op_count_q;
        if (gnt_any) begin
            state_d    = FULL;
            res_data_d = mul_out;
            res_id_d   = gnt_idx;
            op_count_d = op_count_q + 16'd1;
            if (gnt_idx == IDW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + IDW'(1);
            end
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            res_data_q <= '0;
            res_id_q   <= '0;
            ptr_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            ptr_q      <= ptr_d;
            op_count_q <= op_count_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_k_cmult_arb.sv
// Directed bench for k_cmult_arb: vector table plus hand-written
// sequences for back-pressure, reset mid-stream and counter wrap.
module tb_k_cmult_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [15:0]       mul_in0;
    logic [15:0]       mul_in1;
    logic [15:0]       mul_out;
    logic              res_valid;
    logic [15:0]       res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ready;
    logic [15:0]       op_count;

    logic [15:0] a_w [NREQ];
    logic [15:0] b_w [NREQ];
    logic        force_beef;

    int total;
    int bad;
    int exp_cnt;

    k_cmult_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_in0   (mul_in0),
        .mul_in1   (mul_in1),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] fmul(input logic [15:0] a,
                                         input logic [15:0] b);
        return {a[15:8] + b[7:0], a[7:0] ^ b[15:8]};
    endfunction

    assign req_a   = {a_w[3], a_w[2], a_w[1], a_w[0]};
    assign req_b   = {b_w[3], b_w[2], b_w[1], b_w[0]};
    assign mul_out = force_beef ? 16'hBEEF : fmul(mul_in0, mul_in1);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       rr;
        int         gnt;
        logic       vld;
        int         id;
    } vec_t;

    vec_t vt [12];

    initial begin
        total      = 0;
        bad        = 0;
        exp_cnt    = 0;
        force_beef = 1'b0;
        rst        = 1'b1;
        req_valid  = '0;
        res_ready  = 1'b0;
        a_w[0] = 16'h1A2B; b_w[0] = 16'h0C3D;
        a_w[1] = 16'h0102; b_w[1] = 16'h0304;
        a_w[2] = 16'h5566; b_w[2] = 16'h7788;
        a_w[3] = 16'h9ABC; b_w[3] = 16'hDEF0;

        vt[0]  = '{4'b1111, 1'b1,  0, 1'b1, 0};
        vt[1]  = '{4'b1111, 1'b1,  1, 1'b1, 1};
        vt[2]  = '{4'b1001, 1'b1,  3, 1'b1, 3};
        vt[3]  = '{4'b1001, 1'b1,  0, 1'b1, 0};
        vt[4]  = '{4'b0000, 1'b0, -1, 1'b1, 0};
        vt[5]  = '{4'b0100, 1'b0, -1, 1'b1, 0};
        vt[6]  = '{4'b0000, 1'b1, -1, 1'b0, 0};
        vt[7]  = '{4'b0100, 1'b0,  2, 1'b1, 2};
        vt[8]  = '{4'b0011, 1'b1,  0, 1'b1, 0};
        vt[9]  = '{4'b0011, 1'b1,  1, 1'b1, 1};
        vt[10] = '{4'b0001, 1'b1,  0, 1'b1, 0};
        vt[11] = '{4'b0100, 1'b1,  2, 1'b1, 2};

        // reset state, with requests pending while rst is high
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_id", res_id, 0);
        chk("rst_cnt", op_count, 0);
        rst = 1'b0;
        req_valid = '0;

        // table: starts EMPTY, ptr 0
        begin
            logic [15:0] exp_data;
            exp_data = '0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                req_valid = vt[i].rv;
                res_ready = vt[i].rr;
                #1;
                if (vt[i].gnt >= 0) begin
                    chk($sformatf("v%0d_ready", i), req_ready,
                        32'(1) << vt[i].gnt);
                    chk($sformatf("v%0d_in0", i), mul_in0,
                        a_w[vt[i].gnt]);
                    chk($sformatf("v%0d_in1", i), mul_in1,
                        b_w[vt[i].gnt]);
                    exp_data = fmul(a_w[vt[i].gnt], b_w[vt[i].gnt]);
                    exp_cnt++;
                end else begin
                    chk($sformatf("v%0d_ready", i), req_ready, 0);
                    chk($sformatf("v%0d_in0", i), mul_in0, 0);
                end
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_valid", i), res_valid, vt[i].vld);
                if (vt[i].vld) begin
                    chk($sformatf("v%0d_id", i), res_id, vt[i].id);
                    chk($sformatf("v%0d_data", i), res_data, exp_data);
                end
                chk($sformatf("v%0d_cnt", i), op_count, exp_cnt);
            end
        end

        // single request with the bench multiplier forced to BEEF
        do_reset();
        force_beef = 1'b1;
        req_valid  = 4'b0010;
        res_ready  = 1'b0;
        #1;
        chk("single_ready", req_ready, 4'b0010);
        chk("single_in0", mul_in0, 16'h0102);
        chk("single_in1", mul_in1, 16'h0304);
        @(posedge clk);
        #1;
        force_beef = 1'b0;
        req_valid  = '0;
        chk("single_valid", res_valid, 1);
        chk("single_data", res_data, 16'hBEEF);
        chk("single_id", res_id, 1);
        chk("single_cnt", op_count, 1);

        // round robin with all requesters active
        do_reset();
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr%0d_ready", i), req_ready,
                32'(1) << (i % 4));
            @(negedge clk);
        end
        chk("rr_cnt", op_count, 5);
        chk("rr_id", res_id, 0);

        // back-pressure: FULL and res_ready low for 3 cycles
        do_reset();
        req_valid = 4'b0100;
        res_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0001;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_ready", i), req_ready, 0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_id", i), res_id, 2);
            chk($sformatf("bp%0d_data", i), res_data,
                fmul(a_w[2], b_w[2]));
            chk($sformatf("bp%0d_valid", i), res_valid, 1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("bp_release_id", res_id, 0);

        // reset while FULL with res_id=2
        do_reset();
        req_valid = 4'b0100;
        res_ready = 1'b0;
        @(negedge clk);
        chk("mid_id_pre", res_id, 2);
        req_valid = 4'b1111;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_valid_async", res_valid, 0);
        chk("mid_id_async", res_id, 0);
        chk("mid_ready_async", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("mid_first_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("mid_first_id", res_id, 0);

        // op_count wrap after 65536 accepts
        do_reset();
        req_valid = 4'b0001;
        res_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", op_count, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("wrap_zero", op_count, 16'h0000);
        chk("wrap_valid", res_valid, 1);
        chk("wrap_id", res_id, 0);
        chk("wrap_data", res_data, fmul(a_w[0], b_w[0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/k_cmult_arb.md
K_CMULT_ARB -- requirements
Module: k_cmult_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one complex multiplier; legal range 2..8.
REQ-002 SHALL have derived width IDW = max(1, clog2(NREQ)).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  bit i means requester i presents an operand pair.
REQ-006 SHALL have port req_a  input  16*NREQ  operand A of requester i in bits [16i+15:16i]; each word is {imag[15:8], real[7:0]} in the team 8-bit fixed format.
REQ-007 SHALL have port req_b  input  16*NREQ  operand B of requester i, same packing.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot or zero; bit i means requester i is accepted this cycle.
REQ-009 SHALL have port mul_in0  output  16  operand A routed to the shared k_fixedcmult instance.
REQ-010 SHALL have port mul_in1  output  16  operand B routed to the shared multiplier.
REQ-011 SHALL have port mul_out  input  16  combinational product returned by the shared multiplier in the same cycle.
REQ-012 SHALL have port res_valid  output  1  the result register holds a valid product.
REQ-013 SHALL have port res_data  output  16  the registered product.
REQ-014 SHALL have port res_id  output  IDW  the index of the requester that owns res_data.
REQ-015 SHALL have port res_ready  input  1  the consumer accepts res_data this cycle.
REQ-016 SHALL have port op_count  output  16  a count of accepted operations; wraps modulo 2^16.

Function
REQ-017 SHALL keep a two-state output FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-018 SHALL define slot_free = EMPTY or (FULL and res_ready).
REQ-019 SHALL grant, when slot_free holds and any req_valid bit is 1, exactly one requester by round-robin: the lowest index at or above ptr that is valid, otherwise wrapping to 0 and upward.
REQ-020 SHALL assert req_ready[g] only for the granted index g; req_ready SHALL be 0 when slot_free=0 or req_valid=0; req_ready is combinational from req_valid and state.
REQ-021 SHALL drive mul_in0=req_a[g] and mul_in1=req_b[g] during a grant cycle, and 0 on both when there is no grant.
REQ-022 On a grant, SHALL at the clock edge load res_data<=mul_out, res_id<=g, enter FULL, set ptr<=(g+1) mod NREQ, and increment op_count.
REQ-023 SHALL give a latency of exactly 1 cycle: a product accepted at edge k is visible on res_data after edge k.
REQ-024 FULL with res_ready=1 and no grant SHALL go to EMPTY; FULL with res_ready=1 and a grant SHALL stay FULL with new data (back-to-back, 1 op/cycle).
REQ-025 FULL with res_ready=0 SHALL hold res_data, res_id and res_valid stable, and SHALL assert no req_ready.
REQ-026 SHALL leave ptr unchanged in cycles without a grant.
REQ-027 SHALL wrap ptr from NREQ-1 to 0 and op_count from 0xFFFF to 0x0000 with no flag.
REQ-028 SHALL ignore req_a and req_b of ungranted requesters; they do not affect outputs.
REQ-029 SHALL leave the product format to the multiplier; the block performs no arithmetic on data and passes mul_out through unaltered.

Reset
REQ-030 While rst=1, SHALL force, asynchronously: res_valid=0, res_data=0, res_id=0, ptr=0, op_count=0, FSM=EMPTY, req_ready=0.
REQ-031 Reset asserted mid-operation SHALL discard any held result without a handshake; after release, the first grant SHALL start from index 0.

Verification
REQ-032 Single request: NREQ=4, rst then req_valid=0010, req_a=0x0102, req_b=0x0304, bench multiplier returns 0xBEEF -> req_ready=0010 and mul_in0/1=0x0102/0x0304 that cycle; next cycle res_valid=1, res_data=0xBEEF, res_id=1, op_count=1.
REQ-033 Round robin: req_valid=1111 held, res_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles, one per cycle, and op_count=5 after 5 cycles.
REQ-034 Back-pressure: result FULL, res_ready=0 for 3 cycles with req_valid=0001 -> req_ready=0000 and res_data/res_id stable; on res_ready=1, requester 0 is granted that same cycle.
REQ-035 Skip idle requesters: ptr=1, req_valid=1001 -> grant 3, then ptr=0 -> grant 0.
REQ-036 Reset mid-stream: assert rst while FULL with res_id=2 -> res_valid=0 immediately (before the clock edge); after release with req_valid=1111, the first grant is 0.
REQ-037 Counter wrap: preload by 65535 accepts, then 1 more -> op_count=0x0000, with no other effect.
